meter_time_counter: RTL and testbench

- Upstream stage of the 7-segment display controller.
- Holds the parking meter's remaining time as a binary seconds count:
  - adds time on debounced button pulses;
  - loads preset times on reset buttons;
  - counts down once per 1 Hz tick.
- A free-running sequential binary-to-BCD converter publishes four BCD digits and the `parked` warning flag straight into the display controller's `digit3..digit0` and `parked` inputs.

---
 rtl/meter_time_counter_if.sv | 27 ++
 rtl/meter_time_counter.sv | 123 ++++++++++++
 tb/tb_meter_time_counter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/meter_time_counter_if.sv
// Control pulses in, display digits and status out, between the meter
// front end and meter_time_counter.
interface meter_time_counter_if;
    logic       tick_1hz;
    logic       add1;
    logic       add2;
    logic       add3;
    logic       add4;
    logic       rst1;
    logic       rst2;
    logic [3:0] digit3;
    logic [3:0] digit2;
    logic [3:0] digit1;
    logic [3:0] digit0;
    logic       parked;
    logic       expired;

    modport master (
        output tick_1hz, add1, add2, add3, add4, rst1, rst2,
        input  digit3, digit2, digit1, digit0, parked, expired
    );

    modport slave (
        input  tick_1hz, add1, add2, add3, add4, rst1, rst2,
        output digit3, digit2, digit1, digit0, parked, expired
    );
endinterface

// File: rtl/meter_time_counter.sv
// Parking-meter seconds counter with a free-running 16-phase binary-to-BCD converter.
// Optional macro LOW_TIME_WARN_EN: parked flags snapshot < WARN_SEC instead of snapshot == 0.
module meter_time_counter #(
    parameter int unsigned MAX_SEC  = 9999,
    parameter int unsigned WARN_SEC = 180,
    parameter int unsigned RST1_SEC = 15,
    parameter int unsigned RST2_SEC = 150
) (
    input  logic                  clk_fast,
    input  logic                  rst_n,
    meter_time_counter_if.slave   bus
);

`ifdef LOW_TIME_WARN_EN
    localparam bit LOW_WARN = 1'b1;
`else
    localparam bit LOW_WARN = 1'b0;
`endif
    // Without the warning feature, "< 1" is exactly the expiry test.
    localparam logic [13:0] PARK_LIMIT = LOW_WARN ? 14'(WARN_SEC) : 14'd1;
    localparam logic [14:0] MAX15      = 15'(MAX_SEC);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SHIFT,
        ST_PUBLISH
    } conv_state_t;

    logic [13:0] count_q, count_d;
    logic [14:0] dec_val, add_sum, total;

    conv_state_t state_q, state_d;
    logic [3:0]  phase_q, phase_d;
    logic [13:0] shift_q, shift_d;
    logic [15:0] bcd_q, bcd_d, bcd_adj;
    logic        low_q, low_d;
    logic [15:0] digits_q, digits_d;
    logic        parked_q, parked_d;

    always_comb begin
        add_sum = '0;
        if (bus.add1) add_sum = add_sum + 15'd60;
        if (bus.add2) add_sum = add_sum + 15'd120;
        if (bus.add3) add_sum = add_sum + 15'd180;
        if (bus.add4) add_sum = add_sum + 15'd300;

        dec_val = {1'b0, count_q};
        if (bus.tick_1hz && (count_q != '0)) dec_val = dec_val - 15'd1;
        total = dec_val + add_sum;

        if (bus.rst2)          count_d = 14'(RST2_SEC);
        else if (bus.rst1)     count_d = 14'(RST1_SEC);
        else if (total > MAX15) count_d = MAX15[13:0];
        else                   count_d = total[13:0];
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q + 4'd1;
        shift_d  = shift_q;
        bcd_d    = bcd_q;
        low_d    = low_q;
        digits_d = digits_q;
        parked_d = parked_q;

        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end

        case (state_q)
            ST_LOAD: begin
                shift_d = count_q;
                bcd_d   = '0;
                low_d   = (count_q < PARK_LIMIT);
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                {bcd_d, shift_d} = {bcd_adj[14:0], shift_q, 1'b0};
                if (phase_q == 4'd14) state_d = ST_PUBLISH;
            end
            ST_PUBLISH: begin
                digits_d = bcd_q;
                parked_d = low_q;
                state_d  = ST_LOAD;
            end
            default: begin
                state_d = ST_LOAD;
                phase_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_fast) begin
        if (!rst_n) begin
            count_q  <= '0;
            state_q  <= ST_LOAD;
            phase_q  <= '0;
            shift_q  <= '0;
            bcd_q    <= '0;
            low_q    <= 1'b1;
            digits_q <= '0;
            parked_q <= 1'b1;
        end else begin
            count_q  <= count_d;
            state_q  <= state_d;
            phase_q  <= phase_d;
            shift_q  <= shift_d;
            bcd_q    <= bcd_d;
            low_q    <= low_d;
            digits_q <= digits_d;
            parked_q <= parked_d;
        end
    end

    assign bus.digit3  = digits_q[15:12];
    assign bus.digit2  = digits_q[11:8];
    assign bus.digit1  = digits_q[7:4];
    assign bus.digit0  = digits_q[3:0];
    assign bus.parked  = parked_q;
    assign bus.expired = (count_q == '0);

endmodule

// File: tb/tb_meter_time_counter.sv
// Directed bench for meter_time_counter: arithmetic model of count, snapshot and
// publish timing checked every cycle, plus hand-computed checkpoints.
module tb_meter_time_counter;

`ifdef LOW_TIME_WARN_EN
    localparam bit WARN = 1'b1;
`else
    localparam bit WARN = 1'b0;
`endif

    logic clk_fast = 1'b0;
    logic rst_n    = 1'b0;
    meter_time_counter_if bus_if ();

    meter_time_counter dut (
        .clk_fast (clk_fast),
        .rst_n    (rst_n),
        .bus      (bus_if)
    );

    always #5 clk_fast = ~clk_fast;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    int m_count, m_cyc, m_snap, m_parked;
    int m_dig [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: count from the update rules, publish timing as a 16-cycle frame.
    always @(posedge clk_fast) begin
        int s, dec;
        if (!rst_n) begin
            m_count = 0; m_cyc = 0; m_snap = 0; m_parked = 1;
            for (int i = 0; i < 4; i++) m_dig[i] = 0;
        end else begin
            if (m_cyc == 0) m_snap = m_count;
            if (m_cyc == 15) begin
                m_dig[3] = m_snap / 1000;
                m_dig[2] = (m_snap / 100) % 10;
                m_dig[1] = (m_snap / 10) % 10;
                m_dig[0] = m_snap % 10;
                m_parked = WARN ? int'(m_snap < 180) : int'(m_snap == 0);
            end
            s = (bus_if.add1 ? 60 : 0) + (bus_if.add2 ? 120 : 0)
              + (bus_if.add3 ? 180 : 0) + (bus_if.add4 ? 300 : 0);
            dec = (bus_if.tick_1hz && m_count > 0) ? m_count - 1 : m_count;
            if (bus_if.rst2)      m_count = 150;
            else if (bus_if.rst1) m_count = 15;
            else                  m_count = (dec + s > 9999) ? 9999 : dec + s;
            m_cyc = (m_cyc + 1) % 16;
        end
    end

    always @(negedge clk_fast) begin
        if (chk_en) begin
            chk("cyc_digits", {16'h0, bus_if.digit3, bus_if.digit2, bus_if.digit1, bus_if.digit0},
                32'((m_dig[3] << 12) | (m_dig[2] << 8) | (m_dig[1] << 4) | m_dig[0]));
            chk("cyc_parked", 32'(bus_if.parked), 32'(m_parked));
            chk("cyc_expired", 32'(bus_if.expired), 32'(m_count == 0));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_fast);
    endtask

    task automatic lit(input string name, input logic [15:0] dig, input bit p, input bit e);
        chk({name, "_digits"}, {16'h0, bus_if.digit3, bus_if.digit2, bus_if.digit1, bus_if.digit0},
            {16'h0, dig});
        chk({name, "_parked"}, 32'(bus_if.parked), 32'(p));
        chk({name, "_expired"}, 32'(bus_if.expired), 32'(e));
    endtask

    task automatic wait_phase(input int p);
        int k;
        for (k = 0; k < 40; k++) begin
            if (m_cyc == p) break;
            @(negedge clk_fast);
        end
        if (k == 40) begin
            n_assert++;
            n_fail++;
            $display("FAIL wait_phase: phase %0d not reached, got %0d", p, m_cyc);
        end
    endtask

    task automatic clear_inputs();
        bus_if.tick_1hz = 0; bus_if.add1 = 0; bus_if.add2 = 0;
        bus_if.add3 = 0; bus_if.add4 = 0; bus_if.rst1 = 0; bus_if.rst2 = 0;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        cyc(2);
        chk_en = 1'b1;
        lit("reset", 16'h0000, 1'b1, 1'b1);
        rst_n = 1'b1;
        cyc(32);
        lit("idle", 16'h0000, 1'b1, 1'b1);

        bus_if.add4 = 1; cyc(1); bus_if.add4 = 0;
        cyc(32);
        lit("add4", 16'h0300, 1'b0, 1'b0);

        // 300 + 32*300 + 60 = 9960, then ten ticks down to 9950
        bus_if.add4 = 1; cyc(32); bus_if.add4 = 0;
        bus_if.add1 = 1; cyc(1); bus_if.add1 = 0;
        bus_if.tick_1hz = 1; cyc(10); bus_if.tick_1hz = 0;
        cyc(32);
        lit("load9950", 16'h9950, 1'b0, 1'b0);
        bus_if.add1 = 1; bus_if.add2 = 1; cyc(1);
        bus_if.add1 = 0; bus_if.add2 = 0;
        cyc(32);
        lit("saturate", 16'h9999, 1'b0, 1'b0);

        bus_if.rst2 = 1; bus_if.add4 = 1; cyc(1);
        bus_if.rst2 = 0; bus_if.add4 = 0;
        cyc(32);
        lit("rst2_wins", 16'h0150, WARN, 1'b0);
        bus_if.tick_1hz = 1; cyc(149);
        chk("one_left_expired", 32'(bus_if.expired), 32'd0);
        cyc(1);
        chk("count_zero_expired", 32'(bus_if.expired), 32'd1);
        cyc(1); bus_if.tick_1hz = 0;
        chk("no_underflow", 32'(bus_if.expired), 32'd1);
        cyc(32);
        lit("zero", 16'h0000, 1'b1, 1'b1);

        bus_if.rst1 = 1; cyc(1); bus_if.rst1 = 0;
        bus_if.tick_1hz = 1; bus_if.add1 = 1; cyc(1);
        bus_if.tick_1hz = 0; bus_if.add1 = 0;
        cyc(32);
        lit("tick_add", 16'h0074, WARN, 1'b0);

        wait_phase(7);
        bus_if.add3 = 1; cyc(1); bus_if.add3 = 0;
        wait_phase(0);
        lit("first_publish_old", 16'h0074, WARN, 1'b0);
        cyc(1);
        wait_phase(0);
        lit("second_publish_new", 16'h0254, 1'b0, 1'b0);

        cyc(20);
        wait_phase(9);
        rst_n = 1'b0;
        @(posedge clk_fast);
        #1;
        lit("mid_reset", 16'h0000, 1'b1, 1'b1);
        @(negedge clk_fast);
        rst_n = 1'b1;
        cyc(15);
        lit("pre_first_publish", 16'h0000, 1'b1, 1'b1);
        cyc(25);
        lit("post_reset", 16'h0000, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
